vpu_instr_queue: RTL and testbench
==================================

Name: vpu_instr_queue

Overview:
- Vector instruction dispatch buffer between the Rocket scalar core's vector issue port and the VPU decode stage.
- Queues vector instructions together with their scalar operands and stamps each one with a sequence tag.
- Serialises vset* configuration instructions: no later instruction leaves the queue until the VPU acknowledges the new vtype/vl.
- Supports a single-cycle pipeline flush for traps and branch kills.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- XLEN, 64, width of the rs1/rs2 scalar operand fields.
- TAG_W, 5, width of the sequence tag; wraps modulo 2^TAG_W.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- enq_valid  input  1  upstream instruction valid
- enq_ready  output  1  queue can accept
- enq_instr  input  32  raw vector instruction
- enq_rs1  input  XLEN  scalar operand rs1
- enq_rs2  input  XLEN  scalar operand rs2
- deq_valid  output  1  head entry available to VPU decode
- deq_ready  input  1  VPU decode accepts
- deq_instr  output  32  head instruction
- deq_rs1  output  XLEN  head rs1
- deq_rs2  output  XLEN  head rs2
- deq_tag  output  TAG_W  head sequence tag
- cfg_done  input  1  one-cycle pulse from VPU: vset* config committed
- flush  input  1  discard all entries
- count  output  $clog2(DEPTH)+1  current occupancy
- cfg_wait  output  1  queue stalled on an outstanding vset*

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, cfg_wait=0, tag counter=0, pointers=0.
  - Outputs after reset: deq_valid=0, enq_ready=1.
- Enqueue:
  - Handshake is enq_valid & enq_ready.
  - enq_ready = (count<DEPTH) & ~flush. It does not depend on deq_ready, so there is no full-queue pass-through.
  - The entry stores {instr, rs1, rs2, tag}. The tag counter then increments by 1 and wraps from 2^TAG_W-1 to 0.
- Dequeue:
  - deq_valid = (count>0) & ~cfg_wait & ~flush.
  - Handshake is deq_valid & deq_ready; it advances the read pointer.
  - deq_* outputs show the head entry. They stay stable while deq_valid=1 and deq_ready=0.
- Latency: an instruction enqueued at edge N into an empty queue gives deq_valid=1 in the cycle after edge N. There is no combinational enq-to-deq bypass.
- Simultaneous enqueue and dequeue: count is unchanged. When the queue is full, enq_ready=0, so only the dequeue occurs.
- Pointer wrap: both pointers wrap modulo DEPTH. count alone distinguishes full from empty.
- vset* detection is on the dequeued entry: instr[6:0]==7'b1010111 and instr[14:12]==3'b111. This covers vsetvli, vsetivli and vsetvl.
- Config FSM:
  - States are IDLE (cfg_wait=0) and WAIT_CFG (cfg_wait=1).
  - IDLE -> WAIT_CFG on a dequeue handshake of a vset* entry.
  - WAIT_CFG -> IDLE on cfg_done=1.
  - cfg_done is ignored in IDLE and in the same cycle as the vset* handshake.
  - While in WAIT_CFG, enqueue continues normally.
- Flush:
  - Takes effect at the edge where flush=1: count=0, pointers=0, FSM -> IDLE.
  - Overrides any enqueue, dequeue or cfg_done in the same cycle.
  - The tag counter is NOT cleared; tags keep increasing across flushes.
- Reset mid-operation: same state as power-on reset; all entries are dropped and the tag returns to 0.
- Assertion: cfg_done must not be high in two consecutive cycles. The assertion lives in the bench, not in the RTL.

Test Plan:
- Basic ordering:
  - Stimulus: after reset, enqueue 3 non-vset instructions (0x02000057, 0x02100057, 0x02200057) with rs1=1,2,3, holding deq_ready=1.
  - Required: the same order out, tags 0,1,2, first deq_valid one cycle after the first enqueue, count returns to 0.
- Full and wrap:
  - Stimulus: with deq_ready=0, enqueue 9 instructions at DEPTH=8.
  - Required: enq_ready=0 once count=8, and the 9th enqueue is held.
  - Stimulus: then dequeue 4, enqueue 4 more, drain.
  - Required: FIFO order across the pointer wrap, tags 0..11 contiguous.
- vset stall:
  - Stimulus: enqueue vsetvli 0x0C0572D7 followed by 0x02000057.
  - Required: after the vsetvli handshake, cfg_wait=1 and deq_valid=0 for 5 cycles.
  - Stimulus: pulse cfg_done.
  - Required: the next cycle cfg_wait=0, deq_valid=1 showing 0x02000057.
- cfg_done corner:
  - Stimulus: cfg_done asserted in the same cycle as the vset* handshake.
  - Required: it is ignored and cfg_wait stays 1 until a later pulse.
  - Stimulus: cfg_done while in IDLE.
  - Required: no effect.
- Flush:
  - Stimulus: 5 entries queued and in WAIT_CFG; assert flush together with enq_valid.
  - Required: count=0, cfg_wait=0 and deq_valid=0 next cycle; the flushed-cycle enqueue is dropped.
  - Stimulus: next enqueue.
  - Required: it carries tag 5, not 0.
- Reset mid-stream:
  - Stimulus: rst with 3 entries queued and tag counter=7.
  - Required: count=0, enq_ready=1, deq_valid=0; the next enqueued instruction gets tag 0.

Source files
------------

// File: rtl/vpu_instr_queue.sv
// Vector instruction dispatch buffer: FIFO of {instr, rs1, rs2, tag} between the scalar
// core's vector issue port and VPU decode, with vset* serialisation and single-cycle flush.
module vpu_instr_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,

    // Handshakes on both sides: a transfer happens at a rising clk edge where valid and
    // ready are both high; valid never depends on ready, and payload is stable while
    // valid=1 and ready=0.
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_instr,
    input  logic [XLEN-1:0]          enq_rs1,
    input  logic [XLEN-1:0]          enq_rs2,

    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_instr,
    output logic [XLEN-1:0]          deq_rs1,
    output logic [XLEN-1:0]          deq_rs2,
    output logic [TAG_W-1:0]         deq_tag,

    input  logic                     cfg_done,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     cfg_wait
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_WAIT = 1'b1
    } cfg_state_e;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [XLEN-1:0]  rs1_mem_q   [DEPTH];
    logic [XLEN-1:0]  rs2_mem_q   [DEPTH];
    logic [TAG_W-1:0] tag_mem_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [TAG_W-1:0] tag_q,    tag_d;

    cfg_state_e       cfg_state_q;
    logic             cfg_wait_q;

    logic             enq_fire;
    logic             deq_fire;
    logic             head_is_vset;

    // Ready ignores deq_ready on purpose: a full queue never passes an entry straight through.
    assign enq_ready = (count_q < FULL_CNT) & ~flush;
    assign deq_valid = (count_q != '0) & ~cfg_wait_q & ~flush;

    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    assign deq_instr = instr_mem_q[rd_ptr_q];
    assign deq_rs1   = rs1_mem_q[rd_ptr_q];
    assign deq_rs2   = rs2_mem_q[rd_ptr_q];
    assign deq_tag   = tag_mem_q[rd_ptr_q];

    assign count     = count_q;
    assign cfg_wait  = cfg_wait_q;

    // OP-V major opcode with funct3=3'b111 covers vsetvli, vsetivli and vsetvl.
    assign head_is_vset = (deq_instr[6:0] == 7'b1010111) && (deq_instr[14:12] == 3'b111);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tag_d    = tag_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                tag_d    = tag_q + TAG_W'(1);
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Tag counter survives flush so tags stay monotonic across killed instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            instr_mem_q[wr_ptr_q] <= enq_instr;
            rs1_mem_q[wr_ptr_q]   <= enq_rs1;
            rs2_mem_q[wr_ptr_q]   <= enq_rs2;
            tag_mem_q[wr_ptr_q]   <= tag_q;
        end
    end

    // cfg_done in the handshake cycle is ignored because the FSM is still in CFG_IDLE then.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cfg_state_q <= CFG_IDLE;
            cfg_wait_q  <= 1'b0;
        end else begin
            case (cfg_state_q)
                CFG_IDLE: begin
                    if (deq_fire && head_is_vset) begin
                        cfg_state_q <= CFG_WAIT;
                        cfg_wait_q  <= 1'b1;
                    end
                end
                CFG_WAIT: begin
                    if (cfg_done) begin
                        cfg_state_q <= CFG_IDLE;
                        cfg_wait_q  <= 1'b0;
                    end
                end
                default: begin
                    cfg_state_q <= CFG_IDLE;
                    cfg_wait_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_instr_queue.sv
// Bench for vpu_instr_queue: directed scenarios plus random traffic against a queue-based
// reference model; dequeued entries are collected and compared with the model's stream.
module tb_vpu_instr_queue;
    localparam int DEPTH = 8;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EW    = 32 + 2 * XLEN + TAG_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_instr;
    logic [XLEN-1:0]  enq_rs1;
    logic [XLEN-1:0]  enq_rs2;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_instr;
    logic [XLEN-1:0]  deq_rs1;
    logic [XLEN-1:0]  deq_rs2;
    logic [TAG_W-1:0] deq_tag;
    logic             cfg_done;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             cfg_wait;

    always #5 clk = ~clk;

    vpu_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr),
        .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr),
        .deq_rs1(deq_rs1), .deq_rs2(deq_rs2), .deq_tag(deq_tag),
        .cfg_done(cfg_done), .flush(flush), .count(count), .cfg_wait(cfg_wait)
    );

    // Reference model: queue contents, next tag, and whether a vset* is outstanding.
    logic [EW-1:0]    model_q[$];
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    got_q[$];
    logic [TAG_W-1:0] model_tag;
    logic             model_wait;
    int               checks   = 0;
    int               failures = 0;
    logic             cfg_prev = 1'b0;

    always @(posedge clk) begin
        if (cfg_done && cfg_prev) begin
            failures++;
            $display("FAIL cfg_done_consecutive got=1 exp=0 at %0t", $time);
        end
        cfg_prev <= cfg_done;
    end

    function automatic logic is_vset(input logic [31:0] i);
        return (i[6:0] == 7'b1010111) && (i[14:12] == 3'b111);
    endfunction

    function automatic logic [31:0] rand_plain();
        logic [31:0] r;
        r = $urandom;
        if (is_vset(r)) r[12] = 1'b0;
        return r;
    endfunction

    task automatic model_edge();
        logic [EW-1:0] e;
        logic do_enq, do_deq;
        if (rst) begin
            model_q.delete();
            model_tag  = '0;
            model_wait = 1'b0;
        end else if (flush) begin
            model_q.delete();
            model_wait = 1'b0;
        end else begin
            do_deq = deq_ready && (model_q.size() > 0) && !model_wait;
            do_enq = enq_valid && (model_q.size() < DEPTH);
            if (model_wait && cfg_done) model_wait = 1'b0;
            if (do_deq) begin
                e = model_q.pop_front();
                exp_q.push_back(e);
                if (is_vset(e[EW-1 -: 32])) model_wait = 1'b1;
            end
            if (do_enq) begin
                model_q.push_back({enq_instr, enq_rs1, enq_rs2, model_tag});
                model_tag = model_tag + 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst && deq_valid && deq_ready)
            got_q.push_back({deq_instr, deq_rs1, deq_rs2, deq_tag});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0; enq_instr = '0; enq_rs1 = '0; enq_rs2 = '0;
        deq_ready = 1'b0; cfg_done = 1'b0; flush = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        int n;
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        n = 0;
        while (model_q.size() > 0 && n < 4 * DEPTH) begin
            tick();
            n++;
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (count !== '0 || enq_ready !== 1'b1 || deq_valid !== 1'b0 || cfg_wait !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got count=%0d enq_ready=%b deq_valid=%b cfg_wait=%b exp 0 1 0 0",
                     count, enq_ready, deq_valid, cfg_wait);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ins [3];
        ins[0] = 32'h0200_0057; ins[1] = 32'h0210_0057; ins[2] = 32'h0220_0057;
        apply_reset();
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_instr = ins[i];
            enq_rs1   = XLEN'(i + 1);
            enq_rs2   = {$urandom, $urandom};
            tick();
            if (i == 0) begin
                checks++;
                if (deq_valid !== 1'b1 || deq_instr !== ins[0] || deq_tag !== '0 || deq_rs1 !== XLEN'(1)) begin
                    failures++;
                    $display("FAIL basic_latency got valid=%b instr=%h tag=%0d exp 1 %h 0",
                             deq_valid, deq_instr, deq_tag, ins[0]);
                end
            end
        end
        enq_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL basic_count_end got=%0d exp=0", count);
        end
        checks++;
        if (got_q.size() != 3) begin
            failures++;
            $display("FAIL basic_len got=%0d exp=3", got_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (i < 3 && (got_q[i][EW-1 -: 32] !== ins[i] || got_q[i][TAG_W-1:0] !== TAG_W'(i) ||
                          got_q[i][EW-33 -: XLEN] !== XLEN'(i + 1))) begin
                failures++;
                $display("FAIL basic_order[%0d] got instr=%h tag=%0d exp instr=%h tag=%0d",
                         i, got_q[i][EW-1 -: 32], got_q[i][TAG_W-1:0], ins[i], i);
            end
        end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            enq_instr = rand_plain(); enq_rs1 = {$urandom, $urandom}; enq_rs2 = {$urandom, $urandom};
            tick();
        end
        checks++;
        if (count !== CNT_W'(DEPTH) || enq_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_flag got count=%0d enq_ready=%b exp %0d 0", count, enq_ready, DEPTH);
        end
        enq_instr = rand_plain(); enq_rs1 = {$urandom, $urandom}; enq_rs2 = {$urandom, $urandom};
        tick();
        checks++;
        if (count !== CNT_W'(DEPTH) || enq_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_hold got count=%0d enq_ready=%b exp %0d 0", count, enq_ready, DEPTH);
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (count !== CNT_W'(DEPTH - 4)) begin
            failures++;
            $display("FAIL wrap_after_deq got=%0d exp=%0d", count, DEPTH - 4);
        end
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            enq_instr = rand_plain(); enq_rs1 = {$urandom, $urandom}; enq_rs2 = {$urandom, $urandom};
        end
        enq_valid = 1'b0;
        drain();
        checks++;
        if (count !== '0 || got_q.size() != 12) begin
            failures++;
            $display("FAIL wrap_drain got count=%0d popped=%0d exp 0 12", count, got_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i] || got_q[i][TAG_W-1:0] !== TAG_W'(i)) begin
                failures++;
                $display("FAIL wrap_entry[%0d] got tag=%0d instr=%h exp tag=%0d", i,
                         got_q[i][TAG_W-1:0], got_q[i][EW-1 -: 32], i);
            end
        end
    endtask

    task automatic test_vset_stall();
        apply_reset();
        enq_valid = 1'b1;
        enq_instr = 32'h0C05_72D7; enq_rs1 = {$urandom, $urandom}; enq_rs2 = {$urandom, $urandom};
        tick();
        enq_instr = 32'h0200_0057;
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cfg_wait !== 1'b1 || deq_valid !== 1'b0) begin
                failures++;
                $display("FAIL vset_stall[%0d] got cfg_wait=%b deq_valid=%b exp 1 0", i, cfg_wait, deq_valid);
            end
            tick();
        end
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        checks++;
        if (cfg_wait !== 1'b0 || deq_valid !== 1'b1 || deq_instr !== 32'h0200_0057) begin
            failures++;
            $display("FAIL vset_release got cfg_wait=%b deq_valid=%b instr=%h exp 0 1 02000057",
                     cfg_wait, deq_valid, deq_instr);
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() != 2) begin
            failures++;
            $display("FAIL vset_len got=%0d exp=2", got_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL vset_entry[%0d] got=%h", i, got_q[i]);
            end
        end
    endtask

    task automatic test_cfg_corner();
        apply_reset();
        enq_valid = 1'b1;
        enq_instr = 32'h0C05_72D7;
        tick();
        enq_instr = 32'h0200_0057;
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        cfg_done  = 1'b1;
        tick();
        cfg_done  = 1'b0;
        checks++;
        if (cfg_wait !== 1'b1) begin
            failures++;
            $display("FAIL corner_same_cycle got cfg_wait=%b exp 1", cfg_wait);
        end
        tick();
        checks++;
        if (cfg_wait !== 1'b1 || deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL corner_still_wait got cfg_wait=%b deq_valid=%b exp 1 0", cfg_wait, deq_valid);
        end
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        checks++;
        if (cfg_wait !== 1'b0 || deq_valid !== 1'b1) begin
            failures++;
            $display("FAIL corner_release got cfg_wait=%b deq_valid=%b exp 0 1", cfg_wait, deq_valid);
        end
        drain();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        checks++;
        if (cfg_wait !== 1'b0 || count !== '0 || enq_ready !== 1'b1) begin
            failures++;
            $display("FAIL corner_idle_done got cfg_wait=%b count=%0d exp 0 0", cfg_wait, count);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        enq_valid = 1'b1;
        enq_instr = 32'h0C05_72D7;
        tick();
        for (int i = 0; i < 4; i++) begin
            enq_instr = rand_plain(); enq_rs1 = {$urandom, $urandom};
            tick();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        checks++;
        if (count !== CNT_W'(4) || cfg_wait !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup got count=%0d cfg_wait=%b exp 4 1", count, cfg_wait);
        end
        flush = 1'b1;
        enq_valid = 1'b1;
        enq_instr = rand_plain();
        #1;
        checks++;
        if (enq_ready !== 1'b0 || deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_gating got enq_ready=%b deq_valid=%b exp 0 0", enq_ready, deq_valid);
        end
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        checks++;
        if (count !== '0 || cfg_wait !== 1'b0 || deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got count=%0d cfg_wait=%b deq_valid=%b exp 0 0 0",
                     count, cfg_wait, deq_valid);
        end
        enq_valid = 1'b1;
        enq_instr = rand_plain();
        tick();
        enq_valid = 1'b0;
        checks++;
        if (deq_valid !== 1'b1 || deq_tag !== TAG_W'(5) || count !== CNT_W'(1)) begin
            failures++;
            $display("FAIL flush_tag got tag=%0d valid=%b count=%0d exp 5 1 1", deq_tag, deq_valid, count);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        enq_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            enq_instr = rand_plain(); enq_rs1 = {$urandom, $urandom};
            tick();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        repeat (4) tick();
        deq_ready = 1'b0;
        checks++;
        if (count !== CNT_W'(3) || got_q.size() != 4) begin
            failures++;
            $display("FAIL rstmid_setup got count=%0d popped=%0d exp 3 4", count, got_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rstmid_entry[%0d] got=%h", i, got_q[i]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (count !== '0 || enq_ready !== 1'b1 || deq_valid !== 1'b0 || cfg_wait !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state got count=%0d enq_ready=%b deq_valid=%b exp 0 1 0",
                     count, enq_ready, deq_valid);
        end
        enq_valid = 1'b1;
        enq_instr = rand_plain();
        tick();
        enq_valid = 1'b0;
        checks++;
        if (deq_valid !== 1'b1 || deq_tag !== '0) begin
            failures++;
            $display("FAIL rstmid_tag got tag=%0d valid=%b exp 0 1", deq_tag, deq_valid);
        end
        drain();
    endtask

    task automatic test_random();
        logic exp_dv, exp_er;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            enq_valid = ($urandom_range(0, 3) != 0);
            enq_instr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_7057) & 32'hFFFF_FFD7 : rand_plain();
            enq_rs1   = {$urandom, $urandom};
            enq_rs2   = {$urandom, $urandom};
            deq_ready = ($urandom_range(0, 2) != 0);
            cfg_done  = !cfg_done && ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 79) == 0);
            #1;
            exp_dv = (model_q.size() > 0) && !model_wait && !flush;
            exp_er = (model_q.size() < DEPTH) && !flush;
            checks++;
            if (count !== CNT_W'(model_q.size()) || cfg_wait !== model_wait ||
                deq_valid !== exp_dv || enq_ready !== exp_er) begin
                failures++;
                $display("FAIL rand_ctrl[%0d] got count=%0d wait=%b dv=%b er=%b exp %0d %b %b %b", c,
                         count, cfg_wait, deq_valid, enq_ready, model_q.size(), model_wait, exp_dv, exp_er);
            end
            if (exp_dv) begin
                checks++;
                if ({deq_instr, deq_rs1, deq_rs2, deq_tag} !== model_q[0]) begin
                    failures++;
                    $display("FAIL rand_head[%0d] got tag=%0d instr=%h exp tag=%0d instr=%h", c,
                             deq_tag, deq_instr, model_q[0][TAG_W-1:0], model_q[0][EW-1 -: 32]);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (got_q[i]) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_stream[%0d] got tag=%0d", i, got_q[i][TAG_W-1:0]);
            end
        end
    endtask

    initial begin
        model_q.delete();
        model_tag  = '0;
        model_wait = 1'b0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_full_wrap();
        test_vset_stall();
        test_cfg_corner();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
